// File: rtl/ioctl_rom_loader.sv
// ioctl_rom_loader: shares the single-port program/char ROM BRAM between the hps_io download
// stream and CPU fetches. Optional feature macro: LOADER_CHECKSUM_EN (adds the csum output).
module ioctl_rom_loader #(
  parameter int         ADDR_W    = 16,
  parameter logic [7:0] ROM_INDEX = 8'd0
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_data,
  output logic              ioctl_wait,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [7:0]        cpu_dout,
  output logic              cpu_ack,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  input  logic [7:0]        mem_q,
`ifdef LOADER_CHECKSUM_EN
  output logic [7:0]        csum,
`endif
  output logic              load_done
);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    RDW
  } state_t;

  state_t            state;
  state_t            state_next;

  logic              match;
  logic              in_range;
  logic              capture;

  logic              pend;
  logic [ADDR_W-1:0] pend_addr;
  logic [7:0]        pend_data;

  logic              hold_d;

  logic              start_wr;
  logic              start_rd;
  logic              end_wr;
  logic              end_rd;

  assign match    = ioctl_download && (ioctl_index == ROM_INDEX);
  assign in_range = ((ioctl_addr >> ADDR_W) == '0);
  assign capture  = ioctl_wr && match && in_range && !pend;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A byte being captured this cycle counts as a simultaneous write and defers a new read.
  always_comb begin
    state_next = state;
    start_wr   = 1'b0;
    start_rd   = 1'b0;
    end_wr     = 1'b0;
    end_rd     = 1'b0;
    case (state)
      IDLE: begin
        if (pend) begin
          state_next = WR;
          start_wr   = 1'b1;
        end else if (cpu_req && !capture) begin
          state_next = RD;
          start_rd   = 1'b1;
        end
      end
      WR: begin
        state_next = IDLE;
        end_wr     = 1'b1;
      end
      RD: begin
        state_next = RDW;
      end
      RDW: begin
        state_next = IDLE;
        end_rd     = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pend       <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= 8'd0;
      ioctl_wait <= 1'b0;
    end else if (capture) begin
      pend       <= 1'b1;
      pend_addr  <= ioctl_addr[ADDR_W-1:0];
      pend_data  <= ioctl_data;
      ioctl_wait <= 1'b1;
    end else if (end_wr) begin
      pend       <= 1'b0;
      ioctl_wait <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mem_addr <= '0;
      mem_din  <= 8'd0;
      mem_we   <= 1'b0;
    end else if (start_wr) begin
      mem_addr <= pend_addr;
      mem_din  <= pend_data;
      mem_we   <= 1'b1;
    end else if (start_rd) begin
      mem_addr <= cpu_addr;
      mem_we   <= 1'b0;
    end else if (end_wr) begin
      mem_we   <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cpu_dout <= 8'd0;
      cpu_ack  <= 1'b0;
    end else begin
      cpu_ack <= end_rd;
      if (end_rd) begin
        cpu_dout <= mem_q;
      end
    end
  end

  // load_done trails the fall of cpu_hold by one edge, so it needs its own delayed copy.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cpu_hold  <= 1'b0;
      hold_d    <= 1'b0;
      load_done <= 1'b0;
    end else begin
      cpu_hold  <= match;
      hold_d    <= cpu_hold;
      load_done <= hold_d && !cpu_hold;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      csum <= 8'd0;
    end else if (match && !cpu_hold) begin
      csum <= 8'd0;
    end else if (end_wr) begin
      csum <= csum + mem_din;
    end
  end
`endif

endmodule
